// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared state type and constants for the SNN load sequencer
package snn_pkg;

  typedef enum logic [2:0] {
    S_LOAD,
    S_WRITE,
    S_START,
    S_WAIT_DONE,
    S_TX,
    S_TX_WAIT
  } snn_load_state_t;

  localparam int         NUM_PIXELS_DEFAULT = 784;
  localparam logic [7:0] ASCII_ZERO         = 8'h30;

  // Digits 10..15 deliberately run on past '9' into ':'..'?'.
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'h0, digit};
  endfunction

endpackage

// File: rtl/snn_byte_hold.sv
// rtl/snn_byte_hold.sv - one-deep received-byte holding register with sticky overrun
module snn_byte_hold (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] data,
  input  logic       pop,
  output logic       valid,
  output logic [7:0] q,
  output logic       overrun
);

  logic       r_valid;
  logic [7:0] r_q;
  logic       r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_q       <= 8'h00;
      r_overrun <= 1'b0;
    end else begin
      // A byte arriving while the slot drains this cycle replaces it.
      if (push && (!r_valid || pop)) begin
        r_valid <= 1'b1;
        r_q     <= data;
      end else if (pop) begin
        r_valid <= 1'b0;
      end
      if (push && r_valid && !pop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign valid   = r_valid;
  assign q       = r_q;
  assign overrun = r_overrun;

endmodule

// File: rtl/snn_load_ctrl.sv
// rtl/snn_load_ctrl.sv - UART image loader, inference kick-off and ASCII result return
module snn_load_ctrl
  import snn_pkg::*;
#(
  parameter int NUM_PIXELS = NUM_PIXELS_DEFAULT,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_rdy,
  input  logic [7:0]            rx_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_data,
  output logic                  core_start,
  input  logic                  core_done,
  input  logic [3:0]            core_digit,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_rdy,
  output logic                  busy,
  output logic                  overrun
);

  localparam logic [ADDR_WIDTH-1:0] PIX_END = ADDR_WIDTH'(NUM_PIXELS);

  snn_load_state_t       r_state;
  logic [7:0]            r_shift;
  logic [3:0]            r_bit_cnt;
  logic [ADDR_WIDTH-1:0] r_pix_cnt;
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic                  r_ram_data;
  logic                  r_core_start;
  logic                  r_tx_start;
  logic [7:0]            r_tx_data;
  logic                  r_tx_seen_busy;

  logic       w_push;
  logic       w_pop;
  logic       w_hold_valid;
  logic [7:0] w_hold_q;
  logic       w_overrun;
  logic       w_byte_done;
  logic       w_next_bit;
  logic [7:0] w_src;

  assign w_push      = rx_rdy && ((r_state == S_LOAD) || (r_state == S_WRITE));
  assign w_byte_done = (r_state == S_WRITE) && (r_bit_cnt == 4'd8);
  assign w_next_bit  = (r_state == S_WRITE) && (r_bit_cnt != 4'd8);
  // A held byte is taken either from idle or straight after the previous byte's
  // eighth write, unless the image is already complete.
  assign w_pop       = w_hold_valid &&
                       ((r_state == S_LOAD) || (w_byte_done && (r_pix_cnt != PIX_END)));
  assign w_src       = w_pop ? w_hold_q : r_shift;

  snn_byte_hold u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (w_push),
    .data    (rx_data),
    .pop     (w_pop),
    .valid   (w_hold_valid),
    .q       (w_hold_q),
    .overrun (w_overrun)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_LOAD;
      r_shift        <= 8'h00;
      r_bit_cnt      <= 4'd0;
      r_pix_cnt      <= '0;
      r_ram_we       <= 1'b0;
      r_ram_addr     <= '0;
      r_ram_data     <= 1'b0;
      r_core_start   <= 1'b0;
      r_tx_start     <= 1'b0;
      r_tx_data      <= 8'h00;
      r_tx_seen_busy <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      r_tx_start   <= 1'b0;
      case (r_state)
        S_LOAD, S_WRITE: begin
          if (w_pop || w_next_bit) begin
            r_state    <= S_WRITE;
            r_ram_we   <= 1'b1;
            r_ram_addr <= r_pix_cnt;
            r_ram_data <= w_src[0];
            r_shift    <= {1'b0, w_src[7:1]};
            r_bit_cnt  <= w_pop ? 4'd1 : r_bit_cnt + 4'd1;
            r_pix_cnt  <= r_pix_cnt + 1'b1;
          end else begin
            r_ram_we <= 1'b0;
            if (w_byte_done) begin
              if (r_pix_cnt == PIX_END) begin
                r_state      <= S_START;
                r_core_start <= 1'b1;
              end else begin
                r_state <= S_LOAD;
              end
            end
          end
        end
        S_START: begin
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (core_done) begin
            r_tx_data <= digit_to_ascii(core_digit);
            r_state   <= S_TX;
          end
        end
        S_TX: begin
          if (tx_rdy) begin
            r_tx_start     <= 1'b1;
            r_tx_seen_busy <= 1'b0;
            r_state        <= S_TX_WAIT;
          end
        end
        S_TX_WAIT: begin
          // tx_rdy is still high right after the pulse; only a low-then-high counts.
          if (!tx_rdy) begin
            r_tx_seen_busy <= 1'b1;
          end else if (r_tx_seen_busy) begin
            r_pix_cnt <= '0;
            r_state   <= S_LOAD;
          end
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_data   = r_ram_data;
  assign core_start = r_core_start;
  assign tx_start   = r_tx_start;
  assign tx_data    = r_tx_data;
  assign busy       = (r_state != S_LOAD);
  assign overrun    = w_overrun;

endmodule

// File: tb/tb_snn_load_ctrl.sv
// tb/tb_snn_load_ctrl.sv - randomized self-checking bench for snn_load_ctrl
module tb_snn_load_ctrl;

  localparam int NPIX   = 784;
  localparam int NBYTES = NPIX / 8;
  localparam int AW     = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_rdy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic          ram_data;
  logic          core_start;
  logic          core_done = 1'b0;
  logic [3:0]    core_digit = 4'h0;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_rdy = 1'b1;
  logic          busy;
  logic          overrun;

  snn_load_ctrl #(.NUM_PIXELS(NPIX), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .core_start (core_start),
    .core_done  (core_done),
    .core_digit (core_digit),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_rdy     (tx_rdy),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t        wq[$];
  int         start_cyc[$];
  int         txs_cyc[$];
  logic [7:0] txs_data[$];

  always @(negedge clk) begin
    wr_t w;
    if (ram_we === 1'b1) begin
      w.addr = int'(ram_addr);
      w.data = int'(ram_data);
      w.cyc  = cyc;
      wq.push_back(w);
    end
    if (core_start === 1'b1) start_cyc.push_back(cyc);
    if (tx_start === 1'b1) begin
      txs_cyc.push_back(cyc);
      txs_data.push_back(tx_data);
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int at);
    @(posedge clk);
    #1;
    rx_rdy  = 1'b1;
    rx_data = b;
    at      = cyc;
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
  endtask

  // Spacing of at least 8 cycles between bytes never overflows the holding slot.
  task automatic send_image(input logic [7:0] img[$], output int first_rx);
    int at;
    for (int k = 0; k < img.size(); k++) begin
      send_byte(img[k], at);
      if (k == 0) first_rx = at;
      idle($urandom_range(6, 16));
    end
  endtask

  // Reference: byte k bit i lands at address 8k+i, one write per cycle within a byte.
  task automatic check_writes(input string tag, input logic [7:0] img[$], input int first_rx);
    int         n_bad_addr = 0;
    int         n_bad_data = 0;
    int         n_bad_gap  = 0;
    logic [7:0] b;
    chk({tag, "_count"}, wq.size(), img.size() * 8);
    for (int p = 0; p < wq.size() && p < img.size() * 8; p++) begin
      b = img[p / 8];
      if (wq[p].addr != p) n_bad_addr++;
      if (wq[p].data != int'(b[p % 8])) n_bad_data++;
      if ((p % 8) != 0 && wq[p].cyc != wq[p - 1].cyc + 1) n_bad_gap++;
    end
    chk({tag, "_bad_addr"}, n_bad_addr, 0);
    chk({tag, "_bad_data"}, n_bad_data, 0);
    chk({tag, "_intra_byte_gaps"}, n_bad_gap, 0);
    if (wq.size() > 0) chk({tag, "_first_write_latency"}, wq[0].cyc - first_rx, 2);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_data"}, ram_data, 0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 12) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, "_returns_to_load"}, busy, 0);
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] img[$];
    int         first_rx;
    int         at;
    int         n;
    int         dn;
    int         last;
    logic [3:0] dig;
    logic [7:0] b0, b1, b2;

    // Reset values
    idle(3);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Image of 8'hA5 bytes with random byte spacing
    for (int k = 0; k < NBYTES; k++) img.push_back(8'hA5);
    wq.delete();
    start_cyc.delete();
    send_image(img, first_rx);
    idle(20);
    check_writes("img_a5", img, first_rx);
    if (wq.size() > 13) begin
      chk("img_a5_pixel13", wq[13].data, 1);
      chk("img_a5_pixel14", wq[14].data, 0);
    end
    chk("img_a5_core_start_count", start_cyc.size(), 1);
    last = (wq.size() > 0) ? wq[wq.size() - 1].cyc : -100;
    if (start_cyc.size() > 0) chk("img_a5_core_start_cycle", start_cyc[0], last + 1);
    chk("img_a5_busy", busy, 1);
    chk("img_a5_overrun", overrun, 0);

    // Byte arriving in WAIT_DONE is ignored
    n = wq.size();
    send_byte(8'h3C, at);
    idle(14);
    chk("wait_done_rx_writes", wq.size(), n);
    chk("wait_done_rx_overrun", overrun, 0);

    // Result digit 7 with the transmitter idle
    txs_cyc.delete();
    txs_data.delete();
    @(posedge clk);
    #1;
    core_done  = 1'b1;
    core_digit = 4'd7;
    dn         = cyc;
    @(posedge clk);
    #1;
    core_done = 1'b0;
    idle(4);
    chk("result7_tx_start_count", txs_cyc.size(), 1);
    if (txs_cyc.size() > 0) begin
      chk("result7_tx_start_latency", txs_cyc[0] - dn, 2);
      chk("result7_tx_data", txs_data[0], 8'h37);
    end
    chk("result7_waits_for_tx_busy", busy, 1);
    tx_rdy = 1'b0;
    idle(3);
    chk("result7_busy_during_tx", busy, 1);
    tx_rdy = 1'b1;
    wait_idle("result7");
    chk("result7_tx_data_held", tx_data, 8'h37);

    // Back-to-back bytes two cycles apart start again at address 0
    wq.delete();
    img.delete();
    img.push_back(8'h01);
    img.push_back(8'hFF);
    send_byte(img[0], first_rx);
    send_byte(img[1], at);
    idle(24);
    check_writes("b2b", img, first_rx);
    if (wq.size() == 16) chk("b2b_contiguous", wq[15].cyc - wq[0].cyc, 15);
    chk("b2b_overrun", overrun, 0);

    // Continue to 40 bytes, then reset mid-load
    for (int k = 0; k < 38; k++) img.push_back(8'($urandom));
    begin
      logic [7:0] rest[$];
      rest = img[2:$];
      send_image(rest, at);
    end
    idle(20);
    chk("partial40_write_count", wq.size(), 40 * 8);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Full random image after reset
    img.delete();
    for (int k = 0; k < NBYTES; k++) img.push_back(8'($urandom));
    wq.delete();
    start_cyc.delete();
    send_image(img, first_rx);
    idle(20);
    check_writes("img_rand", img, first_rx);
    chk("img_rand_core_start_count", start_cyc.size(), 1);
    last = (wq.size() > 0) ? wq[wq.size() - 1].cyc : -100;
    if (start_cyc.size() > 0) chk("img_rand_core_start_cycle", start_cyc[0], last + 1);

    // Result digit above 9 while the transmitter is busy
    dig = 4'($urandom_range(10, 15));
    txs_cyc.delete();
    txs_data.delete();
    tx_rdy = 1'b0;
    @(posedge clk);
    #1;
    core_done  = 1'b1;
    core_digit = dig;
    @(posedge clk);
    #1;
    core_done = 1'b0;
    idle(6);
    chk("resulthi_no_tx_while_busy", txs_cyc.size(), 0);
    tx_rdy = 1'b1;
    idle(3);
    chk("resulthi_tx_start_count", txs_cyc.size(), 1);
    if (txs_data.size() > 0) chk("resulthi_tx_data", txs_data[0], 8'h30 + {4'h0, dig});
    tx_rdy = 1'b0;
    idle(2);
    tx_rdy = 1'b1;
    wait_idle("resulthi");

    // Three bytes on consecutive cycles: the third is dropped
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    wq.delete();
    @(posedge clk);
    #1;
    rx_rdy   = 1'b1;
    rx_data  = b0;
    first_rx = cyc;
    @(posedge clk);
    #1;
    rx_data = b1;
    @(posedge clk);
    #1;
    rx_data = b2;
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    idle(30);
    img.delete();
    img.push_back(b0);
    img.push_back(b1);
    check_writes("overrun", img, first_rx);
    chk("overrun_flag", overrun, 1);
    send_byte(8'h5A, at);
    idle(20);
    chk("overrun_sticky", overrun, 1);
    chk("overrun_next_byte_writes", wq.size(), 24);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/snn_load_ctrl.md
# snn_load_ctrl

Sequencer between the UART link and the SNN inference core. It takes a 784-pixel binary image as 98 UART bytes, unpacks each byte into eight 1-bit writes to the input-pixel RAM, and pulses the core's start once the last pixel is written. It then waits for the core's done and returns the classified digit over UART as an ASCII character.

## Interface
- NUM_PIXELS, 784, pixels per image; must be a multiple of 8.
- ADDR_WIDTH, 10, input RAM address width; 2**ADDR_WIDTH ≥ NUM_PIXELS.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_rdy  in  1  one-cycle pulse; rx_data is valid that cycle.
- rx_data  in  8  received byte.
- ram_we  out  1  input RAM write enable.
- ram_addr  out  ADDR_WIDTH  input RAM address.
- ram_data  out  1  pixel bit to write.
- core_start  out  1  one-cycle start pulse to the inference core.
- core_done  in  1  one-cycle pulse; core_digit is valid that cycle.
- core_digit  in  4  classified digit.
- tx_start  out  1  one-cycle pulse to the UART transmitter.
- tx_data  out  8  byte to transmit; held stable from tx_start until the next tx_start.
- tx_rdy  in  1  transmitter idle.
- busy  out  1  high in every state except LOAD.
- overrun  out  1  sticky error: a byte was lost. Cleared only by reset.

## Operation
- States: LOAD, WRITE, START, WAIT_DONE, TX, TX_WAIT.
- Reset state is LOAD. Outputs at reset:
  - ram_we=0, ram_addr=0, ram_data=0.
  - core_start=0, tx_start=0, tx_data=0.
  - busy=0, overrun=0.
  - pixel counter=0, byte holding register empty.
- **Byte capture.** A 1-deep holding register (byte + valid) captures rx_data on any rx_rdy in LOAD or WRITE.
  - If rx_rdy arrives while the register is valid and not being consumed that cycle, the new byte is dropped and overrun is set.
  - rx_rdy in START, WAIT_DONE, TX or TX_WAIT is ignored (no capture, no overrun).
- **LOAD.**
  - When the holding register is valid, it is moved into a shift register, the holding register is cleared, and the state goes to WRITE.
  - When rx_rdy and an empty holding register coincide, the byte is captured and consumed the next cycle.
- **WRITE.** Runs 8 cycles. Each cycle:
  - ram_we=1, ram_addr=pixel counter, ram_data=shift[0].
  - Then shift right and increment the pixel counter.
  - Bit order: byte k bit i maps to pixel 8k+i (LSB first).
- **After WRITE.**
  - If the pixel counter equals NUM_PIXELS, go to START.
  - Otherwise, if the holding register is valid, reload the shift register and stay in WRITE.
  - Otherwise go to LOAD.
- **START.** core_start=1 for exactly one cycle, then go to WAIT_DONE.
- **WAIT_DONE.** On core_done, latch tx_data = 8'h30 + {4'h0, core_digit} (unclamped; digits 10–15 give 8'h3A–8'h3F), then go to TX.
- **TX.**
  - When tx_rdy=1, pulse tx_start for one cycle and go to TX_WAIT.
  - If tx_rdy=0, hold in TX with no tx_start.
- **TX_WAIT.**
  - The transmitter must be seen busy first: wait for tx_rdy=0, then wait for tx_rdy=1.
  - Then clear the pixel counter and go to LOAD.
- **Reset mid-operation.** Returns to LOAD with all counters cleared. Partially loaded pixels are abandoned; RAM contents are not cleared.

## Timing
- First RAM write occurs 2 cycles after the rx_rdy that carries byte 0: capture, then LOAD→WRITE.
- The 8 writes for a byte occupy 8 consecutive cycles.
- Back-to-back held bytes produce 16 contiguous write cycles with no gap.
- core_start rises the cycle after the write to pixel NUM_PIXELS-1.
- tx_start rises 2 cycles after core_done when tx_rdy is already 1 (WAIT_DONE→TX, then TX pulse).
- The pixel counter is ADDR_WIDTH bits wide and never wraps. The NUM_PIXELS compare occurs before any further write.
- At a baud period of 2604 clocks, bytes arrive more than 26000 cycles apart, so overrun indicates a protocol fault only.

## Structure
- Shared package snn_pkg holds:
  - the state enum snn_load_state_t;
  - NUM_PIXELS_DEFAULT=784;
  - ASCII_ZERO=8'h30.
- One sub-module, snn_byte_hold: the 1-deep holding register with overrun detection. Inputs: push, data, pop. Outputs: valid, q, overrun.
- FSM, shift register and counter live in the top module.

## Test plan
- **Single image.** Send 98 bytes of 8'hA5 -> 784 RAM writes; pixel 8k+0=1, 8k+1=0, 8k+2=1, 8k+5=1, 8k+7=1; exactly one core_start, the cycle after the write to address 783.
- **Result return.** core_done with core_digit=7 and tx_rdy=1 -> tx_start 2 cycles later, tx_data=8'h37; after tx_rdy toggles 0→1, state LOAD, busy=0, next write goes to address 0.
- **Back-to-back bytes.** rx_rdy on bytes 8'h01 and 8'hFF two cycles apart -> 16 contiguous ram_we cycles at addresses 0–15, data 1,0×7,1×8; overrun=0.
- **Overrun.** Three rx_rdy pulses on consecutive cycles at idle -> third byte dropped, overrun=1 and stays 1; only 16 writes occur.
- **Ignored input.** rx_rdy during WAIT_DONE -> no RAM write, overrun stays 0.
- **Reset mid-load.** Assert rst_n=0 after 40 bytes -> all outputs at reset values immediately; 98 further bytes write addresses 0–783 and produce one core_start.
